// File: rtl/count_pkg.sv
// Shared constants and helpers for the BCD counter family: BCD digit width,
// decimal-to-BCD conversion for elaboration-time constants, and digit validity.
package count_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;

  // Packed BCD image of a decimal integer; digits above 'digits' are left at zero.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] int_to_bcd(input int value, input int digits);
    logic [BCD_W*MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[i*BCD_W +: BCD_W] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [BCD_W*MAX_DIGITS-1:0] vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (vec[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down chain: steps on inc or dec and reports the
// carry (9 -> 0) or borrow (0 -> 9) into the next digit.
module bcd_digit
  import count_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             carry,
  output logic             borrow
);

  always_comb begin
    q = d;
    if (inc) begin
      q = (d == 4'd9) ? 4'd0 : d + 4'd1;
    end else if (dec) begin
      q = (d == 4'd0) ? 4'd9 : d - 4'd1;
    end
  end

  assign carry  = inc & (d == 4'd9);
  assign borrow = dec & (d == 4'd0);

endmodule

// File: rtl/bcd_count_ud.sv
// N-digit cascadable up/down BCD counter with configurable maximum,
// validated synchronous load, combinational tc and registered wrap/err pulses.
module bcd_count_ud
  import count_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MAX    = 99
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] out,
  output logic                    tc,
  output logic                    wrap,
  output logic                    err
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [BCD_W*MAX_DIGITS-1:0] MAX_FULL = int_to_bcd(MAX, DIGITS);
  localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];

  logic          step_up;
  logic          step_dn;
  logic          at_max;
  logic          at_zero;
  logic          load_ok;
  logic [W-1:0]  chain_val;
  logic [W-1:0]  step_val;
  logic [DIGITS:0] carry;
  logic [DIGITS:0] borrow;
  logic          unused_chain;

  assign step_up = enable & ~load & up;
  assign step_dn = enable & ~load & ~up;
  assign at_max  = (out == MAX_BCD);
  assign at_zero = (out == '0);

  assign tc = (step_up & at_max) | (step_dn & at_zero);

  // Plain BCD ripple; the terminal override below replaces it at MAX and 0.
  assign carry[0]  = step_up;
  assign borrow[0] = step_dn;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .d      (out[i*BCD_W +: BCD_W]),
      .inc    (carry[i]),
      .dec    (borrow[i]),
      .q      (chain_val[i*BCD_W +: BCD_W]),
      .carry  (carry[i+1]),
      .borrow (borrow[i+1])
    );
  end

  // Top-digit carry/borrow can only occur at terminal values, which the override covers.
  assign unused_chain = carry[DIGITS] | borrow[DIGITS];

  always_comb begin
    step_val = chain_val;
    if (step_up && at_max) begin
      step_val = '0;
    end else if (step_dn && at_zero) begin
      step_val = MAX_BCD;
    end
  end

  // Valid BCD digits compare in the same order as their decimal values.
  assign load_ok = bcd_valid(32'(load_val)) && (load_val <= MAX_BCD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (load) begin
        if (load_ok) begin
          out <= load_val;
        end else begin
          err <= 1'b1;
        end
      end else if (enable) begin
        out  <= step_val;
        wrap <= tc;
      end
    end
  end

endmodule

// File: tb/tb_bcd_count_ud.sv
// Bench for bcd_count_ud: MAX=99 and MAX=59 instances share stimulus, plus a
// two-stage DIGITS=1 cascade; directed vector table, reset sequence, random run.
module tb_bcd_count_ud;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, ld;
  logic [7:0] lv;
  logic [7:0] o99, o59;
  logic       tc99, w99, e99, tc59, w59, e59;

  logic       c_en;
  logic [3:0] lo_out, hi_out;
  logic       lo_tc, lo_wrap, lo_err, hi_tc, hi_wrap, hi_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_count_ud #(.DIGITS(2), .MAX(99)) u99 (
    .clk(clk), .rst(rst), .enable(en), .up(up), .load(ld), .load_val(lv),
    .out(o99), .tc(tc99), .wrap(w99), .err(e99)
  );

  bcd_count_ud #(.DIGITS(2), .MAX(59)) u59 (
    .clk(clk), .rst(rst), .enable(en), .up(up), .load(ld), .load_val(lv),
    .out(o59), .tc(tc59), .wrap(w59), .err(e59)
  );

  bcd_count_ud #(.DIGITS(1), .MAX(9)) u_lo (
    .clk(clk), .rst(rst), .enable(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .out(lo_out), .tc(lo_tc), .wrap(lo_wrap), .err(lo_err)
  );

  bcd_count_ud #(.DIGITS(1), .MAX(9)) u_hi (
    .clk(clk), .rst(rst), .enable(lo_tc), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .out(hi_out), .tc(hi_tc), .wrap(hi_wrap), .err(hi_err)
  );

  typedef struct {
    bit         en, up, ld;
    logic [7:0] lv;
    logic [7:0] o99;
    bit         t99, w99, r99;
    logic [7:0] o59;
    bit         t59, w59, r59;
  } vec_t;

  vec_t vecs[$];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Decimal reference: state is a plain integer, BCD appears only at compare time.
  function automatic void model(input int mx, input bit en_i, input bit up_i, input bit ld_i,
                                input logic [7:0] lv_i, inout int v,
                                output bit t, output bit w, output bit e);
    int lval;
    bit ok;
    ok   = (lv_i[3:0] <= 4'd9) && (lv_i[7:4] <= 4'd9);
    lval = 10 * int'(lv_i[7:4]) + int'(lv_i[3:0]);
    ok   = ok && (lval <= mx);
    t = en_i && !ld_i && ((up_i && v == mx) || (!up_i && v == 0));
    w = 1'b0;
    e = 1'b0;
    if (ld_i) begin
      if (ok) v = lval;
      else    e = 1'b1;
    end else if (en_i) begin
      w = t;
      if (up_i) v = (v == mx) ? 0 : v + 1;
      else      v = (v == 0) ? mx : v - 1;
    end
  endfunction

  task automatic add(input bit e_, input bit u_, input bit l_, input logic [7:0] lv_,
                     input logic [7:0] a_o, input bit a_t, input bit a_w, input bit a_r,
                     input logic [7:0] b_o, input bit b_t, input bit b_w, input bit b_r);
    vec_t v;
    v.en = e_; v.up = u_; v.ld = l_; v.lv = lv_;
    v.o99 = a_o; v.t99 = a_t; v.w99 = a_w; v.r99 = a_r;
    v.o59 = b_o; v.t59 = b_t; v.w59 = b_w; v.r59 = b_r;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit e_, input bit u_, input bit l_, input logic [7:0] lv_);
    @(negedge clk);
    en = e_; up = u_; ld = l_; lv = lv_;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    en = 1'b0; up = 1'b1; ld = 1'b0; lv = 8'h00; c_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int m99, m59;
    bit t_a, w_a, r_a, t_b, w_b, r_b;

    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; lv = 8'h00; c_en = 1'b0;
    #1;
    chk8("reset o99", o99, 8'h00);
    chk1("reset w99", w99, 1'b0);
    chk1("reset e99", e99, 1'b0);
    chk1("reset tc99", tc99, 1'b0);
    chk8("reset o59", o59, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    //  en up ld lv     | o99  t  w  r | o59  t  w  r
    add(0, 0, 1, 8'h98,   8'h98, 0, 0, 0,  8'h00, 0, 0, 1);
    add(1, 1, 0, 8'h00,   8'h99, 0, 0, 0,  8'h01, 0, 0, 0);
    add(1, 1, 0, 8'h00,   8'h00, 1, 1, 0,  8'h02, 0, 0, 0);
    add(1, 1, 0, 8'h00,   8'h01, 0, 0, 0,  8'h03, 0, 0, 0);
    add(0, 0, 1, 8'h10,   8'h10, 0, 0, 0,  8'h10, 0, 0, 0);
    add(1, 0, 0, 8'h00,   8'h09, 0, 0, 0,  8'h09, 0, 0, 0);
    add(1, 0, 0, 8'h00,   8'h08, 0, 0, 0,  8'h08, 0, 0, 0);
    add(0, 0, 1, 8'h00,   8'h00, 0, 0, 0,  8'h00, 0, 0, 0);
    add(1, 0, 0, 8'h00,   8'h99, 1, 1, 0,  8'h59, 1, 1, 0);
    add(0, 0, 1, 8'h58,   8'h58, 0, 0, 0,  8'h58, 0, 0, 0);
    add(1, 1, 0, 8'h00,   8'h59, 0, 0, 0,  8'h59, 0, 0, 0);
    add(1, 1, 0, 8'h00,   8'h60, 0, 0, 0,  8'h00, 1, 1, 0);
    add(1, 0, 0, 8'h00,   8'h59, 0, 0, 0,  8'h59, 1, 1, 0);
    add(0, 0, 1, 8'h4A,   8'h59, 0, 0, 1,  8'h59, 0, 0, 1);
    add(0, 0, 1, 8'h60,   8'h60, 0, 0, 0,  8'h59, 0, 0, 1);
    add(1, 1, 1, 8'h42,   8'h42, 0, 0, 0,  8'h42, 0, 0, 0);
    add(0, 1, 0, 8'h00,   8'h42, 0, 0, 0,  8'h42, 0, 0, 0);
    add(1, 0, 1, 8'h9F,   8'h42, 0, 0, 1,  8'h42, 0, 0, 1);
    add(1, 1, 1, 8'h99,   8'h99, 0, 0, 0,  8'h42, 0, 0, 1);
    add(1, 1, 0, 8'h00,   8'h00, 1, 1, 0,  8'h43, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv);
      #1;
      chk1($sformatf("v%0d tc99", i), tc99, vecs[i].t99);
      chk1($sformatf("v%0d tc59", i), tc59, vecs[i].t59);
      @(posedge clk);
      #1;
      chk8($sformatf("v%0d o99", i), o99, vecs[i].o99);
      chk1($sformatf("v%0d w99", i), w99, vecs[i].w99);
      chk1($sformatf("v%0d e99", i), e99, vecs[i].r99);
      chk8($sformatf("v%0d o59", i), o59, vecs[i].o59);
      chk1($sformatf("v%0d w59", i), w59, vecs[i].w59);
      chk1($sformatf("v%0d e59", i), e59, vecs[i].r59);
    end

    // Asynchronous reset mid-count at 37, then resume 00, 01, 02.
    drive(0, 1, 1, 8'h36);
    drive(1, 1, 0, 8'h00);
    @(posedge clk);
    #1;
    chk8("pre-rst o99", o99, 8'h37);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk8("async rst o99", o99, 8'h00);
    chk8("async rst o59", o59, 8'h00);
    chk1("async rst w99", w99, 1'b0);
    chk1("async rst e99", e99, 1'b0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = 1'b1; ld = 1'b0;
    #1;
    chk8("resume 0", o99, 8'h00);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      chk8($sformatf("resume %0d", k), o99, to_bcd(k));
    end

    // Random run against the decimal model.
    pulse_reset();
    m99 = 0;
    m59 = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : to_bcd($urandom_range(0, 99));
      model(99, en, up, ld, lv, m99, t_a, w_a, r_a);
      model(59, en, up, ld, lv, m59, t_b, w_b, r_b);
      #1;
      chk1($sformatf("rnd%0d tc99", n), tc99, t_a);
      chk1($sformatf("rnd%0d tc59", n), tc59, t_b);
      @(posedge clk);
      #1;
      chk8($sformatf("rnd%0d o99", n), o99, to_bcd(m99));
      chk1($sformatf("rnd%0d w99", n), w99, w_a);
      chk1($sformatf("rnd%0d e99", n), e99, r_a);
      chk8($sformatf("rnd%0d o59", n), o59, to_bcd(m59));
      chk1($sformatf("rnd%0d w59", n), w59, w_b);
      chk1($sformatf("rnd%0d e59", n), e59, r_b);
    end

    // Two-stage cascade: 25 enabled steps reads 2,5.
    pulse_reset();
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      c_en = 1'b1;
      @(posedge clk);
      #1;
      chk8($sformatf("cascade %0d", k), {hi_out, lo_out}, to_bcd(k));
    end
    @(negedge clk);
    c_en = 1'b0;
    @(posedge clk);
    #1;
    chk8("cascade lo final", {4'h0, lo_out}, 8'h05);
    chk8("cascade hi final", {4'h0, hi_out}, 8'h02);
    chk1("cascade lo err", lo_err, 1'b0);
    chk1("cascade hi wrap", hi_wrap, 1'b0);
    chk1("cascade hi tc", hi_tc, 1'b0);
    chk1("cascade hi err", hi_err, 1'b0);
    chk1("cascade lo wrap", lo_wrap, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
